// File: rtl/q_8_34b_datapath.sv
// Datapath for the q_8_34b ones counter: R1 shift register, E flag, R2 ones count.
// Executes controller commands, reports zero/E status, and captures the final count.
module q_8_34b_datapath #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_regs,
    input  logic             incr_r2,
    input  logic             shift,
    output logic             zero,
    output logic             E,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    logic [WIDTH-1:0] r1;
    logic [CW-1:0]    r2;
    logic [CW-1:0]    r2_inc;
    logic             e_q;
    logic [CW-1:0]    result_q;
    logic             done_q;
    logic             busy_q;
    logic             err_q;
    logic             finish;
    logic             misuse;

    assign r2_inc = r2 + 1'b1;
    assign zero   = (r1 == '0);

    // The final increment lands while R1 is already empty; that edge closes the run.
    assign finish = busy_q && incr_r2 && zero && !load_regs;
    assign misuse = (shift || incr_r2) && !busy_q && !load_regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1       <= '0;
            e_q      <= 1'b0;
            r2       <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_regs) begin
                r1     <= data_in;
                r2     <= '1;
                e_q    <= 1'b0;
                busy_q <= 1'b1;
            end else begin
                if (shift) begin
                    e_q <= r1[WIDTH-1];
                    r1  <= {r1[WIDTH-2:0], 1'b0};
                end
                if (incr_r2) begin
                    r2 <= r2_inc;
                end
                if (finish) begin
                    result_q <= r2_inc;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end
            end
            // Misuse is flagged but the command above still executes.
            if (misuse) begin
                err_q <= 1'b1;
            end
        end
    end

    assign E      = e_q;
    assign count  = r2;
    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_q_8_34b_datapath.sv
// Directed bench for q_8_34b_datapath, with a behavioural ones-counting controller
// steering the datapath through its zero/E status.
module tb_q_8_34b_datapath;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_regs;
    logic             incr_r2;
    logic             shift;
    logic             zero;
    logic             E;
    logic [CW-1:0]    count;
    logic [CW-1:0]    result;
    logic             done;
    logic             busy;
    logic             err;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    logic e_first;
    logic zero_8th;

    q_8_34b_datapath #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load_regs(load_regs),
        .incr_r2  (incr_r2),
        .shift    (shift),
        .zero     (zero),
        .E        (E),
        .count    (count),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic idle_cmds();
        load_regs = 1'b0;
        incr_r2   = 1'b0;
        shift     = 1'b0;
    endtask

    // Behavioural controller: S_idle load, S_1 incr (exit on zero), S_2 shift, S_3 test E.
    // Returns at the falling edge after the final S_1 edge, where done should be high.
    task automatic run_ctrl(input logic [7:0] d);
        int  st;
        int  shifts;
        bit  fin;
        e_first  = 1'bx;
        zero_8th = 1'bx;
        @(negedge clk);
        data_in   = d;
        load_regs = 1'b1;
        incr_r2   = 1'b0;
        shift     = 1'b0;
        @(negedge clk);
        load_regs = 1'b0;
        st     = 1;
        shifts = 0;
        fin    = 1'b0;
        for (int i = 0; i < 64 && !fin; i++) begin
            incr_r2 = 1'b0;
            shift   = 1'b0;
            case (st)
                1: begin
                    incr_r2 = 1'b1;
                    if (zero) fin = 1'b1;
                    else st = 2;
                end
                2: begin
                    shift = 1'b1;
                    st = 3;
                end
                default: st = E ? 1 : 2;
            endcase
            @(negedge clk);
            if (shift) begin
                shifts++;
                if (shifts == 1) e_first = E;
                if (shifts == 8) zero_8th = zero;
            end
            incr_r2 = 1'b0;
            shift   = 1'b0;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL ctrl_timeout data=%h: sequence did not terminate in 64 cycles", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_in   = 8'($urandom);
            load_regs = 1'($urandom);
            incr_r2   = 1'($urandom);
            shift     = 1'($urandom);
        end
        @(negedge clk);
        checks++; if ({E, count, result, done, busy, err, zero} !== {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: E=%b count=%0d result=%0d done=%b busy=%b err=%b zero=%b, want 0 0 0 0 0 0 1",
                     E, count, result, done, busy, err, zero);
        end
        idle_cmds();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_popcount_b2();
        done_seen = 0;
        run_ctrl(8'b1011_0010);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2_done: got %b want 1", done); end
        checks++; if (result !== 4'd4) begin failures++; $display("FAIL b2_result: got %0d want 4", result); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2_busy_falls: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2_err: got %b want 0", err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2_done_pulse: got %b want 0", done); end
        checks++; if (done_seen !== 1) begin failures++; $display("FAIL b2_done_count: got %0d want 1", done_seen); end
    endtask

    task automatic test_zero_data();
        done_seen = 0;
        data_in   = 8'h00;
        load_regs = 1'b1;
        @(negedge clk);
        load_regs = 1'b0;
        checks++; if (zero !== 1'b1 || count !== 4'hF) begin
            failures++; $display("FAIL z_after_load: zero=%b count=%0d want 1 15", zero, count);
        end
        incr_r2 = 1'b1;
        @(negedge clk);
        incr_r2 = 1'b0;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL z_count: got %0d want 0", count); end
        checks++; if (done !== 1'b1 || result !== 4'd0) begin
            failures++; $display("FAIL z_done: done=%b result=%0d want 1 0", done, result);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || done_seen !== 1) begin
            failures++; $display("FAIL z_done_once: done=%b seen=%0d want 0 1", done, done_seen);
        end
    endtask

    task automatic test_all_ones();
        run_ctrl(8'hFF);
        checks++; if (result !== 4'd8) begin failures++; $display("FAIL ff_result: got %0d want 8", result); end
        checks++; if (e_first !== 1'b1) begin failures++; $display("FAIL ff_e_first: got %b want 1", e_first); end
        checks++; if (zero_8th !== 1'b1) begin failures++; $display("FAIL ff_zero_8th: got %b want 1", zero_8th); end
        @(negedge clk);
    endtask

    task automatic test_restart();
        done_seen = 0;
        data_in   = 8'hF0;
        load_regs = 1'b1;
        @(negedge clk);
        load_regs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shift = 1'b1;
            @(negedge clk);
        end
        shift = 1'b0;
        run_ctrl(8'h01);
        checks++; if (result !== 4'd1) begin failures++; $display("FAIL restart_result: got %0d want 1", result); end
        @(negedge clk);
        checks++; if (done_seen !== 1) begin failures++; $display("FAIL restart_done_count: got %0d want 1", done_seen); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL restart_err: got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        done_seen = 0;
        data_in   = 8'hAA;
        load_regs = 1'b1;
        @(negedge clk);
        load_regs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shift = 1'b1;
            @(negedge clk);
        end
        shift = 1'b0;
        checks++; if (E !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_pre: E=%b busy=%b want 1 1", E, busy);
        end
        rst     = 1'b1;
        incr_r2 = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        incr_r2 = 1'b0;
        checks++; if ({E, count, result, done, busy, err, zero} !== {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_state: E=%b count=%0d result=%0d done=%b busy=%b err=%b zero=%b, want 0 0 0 0 0 0 1",
                     E, count, result, done, busy, err, zero);
        end
        @(negedge clk);
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL mid_no_done: got %0d want 0", done_seen); end
    endtask

    task automatic test_err_sticky();
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", err); end
        checks++; if (E !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL err_exec: E=%b busy=%b want 0 0", E, busy);
        end
        run_ctrl(8'b0001_0101);
        checks++; if (result !== 4'd3 || done !== 1'b1) begin
            failures++; $display("FAIL err_seq_result: result=%0d done=%b want 3 1", result, done);
        end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_shift_incr_together();
        data_in   = 8'h80;
        load_regs = 1'b1;
        @(negedge clk);
        load_regs = 1'b0;
        shift     = 1'b1;
        incr_r2   = 1'b1;
        @(negedge clk);
        idle_cmds();
        checks++; if (E !== 1'b1 || count !== 4'd0 || zero !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL both_cmds: E=%b count=%0d zero=%b done=%b want 1 0 1 0", E, count, zero, done);
        end
        load_regs = 1'b1;
        incr_r2   = 1'b1;
        shift     = 1'b1;
        data_in   = 8'h3C;
        @(negedge clk);
        idle_cmds();
        checks++; if (count !== 4'hF || E !== 1'b0 || zero !== 1'b0) begin
            failures++; $display("FAIL load_priority: count=%0d E=%b zero=%b want 15 0 0", count, E, zero);
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_in = '0;
        idle_cmds();
        test_reset();
        test_popcount_b2();
        test_zero_data();
        test_all_ones();
        test_restart();
        test_reset_mid();
        test_err_sticky();
        test_shift_incr_together();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
